// File: rtl/apb_pkg.sv
// Shared address-map constants, index-width helper and APB phase encodings
// for the APB register completer.
package apb_pkg;

   localparam int REG_STRIDE = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_phase_e;

   function automatic int idx_width(input int num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

   function automatic int slow_base(input int num_regs);
      return num_regs / 2;
   endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register array: one synchronous write port, one combinational read port,
// asynchronous clear of every entry.
module apb_reg_bank
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16,
   parameter int IDX_W      = idx_width(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [IDX_W-1:0]      index,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               regs_reg[gi] <= '0;
            end else if (we && (index == IDX_W'(gi))) begin
               regs_reg[gi] <= wdata;
            end
         end
      end
   endgenerate

   assign rdata = regs_reg[index];

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer over a register bank: lower half zero-wait, upper half
// stretched by WAIT_CYCLES, out-of-range addresses answered with PSLVERR.
module apb_reg_slave
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_CYCLES = 3
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic                  PWRITE,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PSELx,
   input  logic                  PENABLE,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   localparam int IDX_W = idx_width(NUM_REGS);
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [ADDR_WIDTH-1:0] MAP_END   = ADDR_WIDTH'(REG_STRIDE * NUM_REGS);
   localparam logic [IDX_W-1:0]      SLOW_BASE = IDX_W'(slow_base(NUM_REGS));
   localparam logic [CNT_W-1:0]      WAIT_LOAD = CNT_W'(WAIT_CYCLES);

   apb_phase_e            phase;
   logic [IDX_W-1:0]      index;
   logic                  valid;
   logic                  slow;
   logic [CNT_W-1:0]      cnt_reg;
   logic [CNT_W-1:0]      cnt_next;
   logic                  ready;
   logic                  we;
   logic [DATA_WIDTH-1:0] rd_data;

   assign index = PADDR[IDX_W+1:2];
   assign valid = (PADDR < MAP_END);
   assign slow  = valid && (index >= SLOW_BASE);

   always_comb begin
      phase = IDLE;
      if (PSELx) begin
         phase = PENABLE ? ACCESS : SETUP;
      end
   end

   // Anything other than setup/access clears the counter, which is what
   // aborts a transfer whose select or enable drops mid-wait.
   always_comb begin
      cnt_next = '0;
      case (phase)
         SETUP:   cnt_next = slow ? WAIT_LOAD : '0;
         ACCESS:  cnt_next = (cnt_reg != '0) ? (cnt_reg - CNT_W'(1)) : '0;
         default: cnt_next = '0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   // Outputs are combinational, so reset must gate them to hold them low.
   assign ready   = (phase == ACCESS) && (cnt_reg == '0) && !i_reset;
   assign we      = ready && PWRITE && valid;
   assign PREADY  = ready;
   assign PSLVERR = ready && !valid;
   assign PRDATA  = (ready && !PWRITE && valid) ? rd_data : '0;

   apb_reg_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (IDX_W)
   ) u_bank (
      .clk   (i_clk),
      .rst   (i_reset),
      .we    (we),
      .index (index),
      .wdata (PWDATA),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench: the driver pushes expected responses from a register-array
// model, a negedge monitor pops and checks them on every PREADY.
module tb_apb_reg_slave;

   localparam int NREGS = 16;
   localparam int WAITS = 3;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [31:0] PADDR = '0;
   logic        PWRITE = 1'b0;
   logic [31:0] PWDATA = '0;
   logic        PSELx = 1'b0;
   logic        PENABLE = 1'b0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   apb_reg_slave #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .NUM_REGS    (NREGS),
      .WAIT_CYCLES (WAITS)
   ) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .PADDR   (PADDR),
      .PWRITE  (PWRITE),
      .PWDATA  (PWDATA),
      .PSELx   (PSELx),
      .PENABLE (PENABLE),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int          waits;
      logic        err;
      logic [31:0] rdata;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model [NREGS];
   int          checks = 0;
   int          errors = 0;
   int          mon_waits = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Monitor: counts access cycles before PREADY and checks the popped entry.
   always @(negedge i_clk) begin
      if (i_reset) begin
         mon_waits = 0;
      end else if (PSELx && PENABLE) begin
         if (PREADY) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ready: got PREADY=1 with no transfer expected");
            end else begin
               e = exp_q.pop_front();
               check32({e.name, "_waits"}, 32'(mon_waits), 32'(e.waits));
               check32({e.name, "_pslverr"}, {31'd0, PSLVERR}, {31'd0, e.err});
               check32({e.name, "_prdata"}, PRDATA, e.rdata);
               $display("xfer %s addr=%h wr=%0d waits=%0d err=%0d rdata=%h", e.name, PADDR, PWRITE, mon_waits, PSLVERR, PRDATA);
            end
            mon_waits = 0;
         end else begin
            mon_waits++;
         end
      end else begin
         mon_waits = 0;
         check32("ready_outside_access", {31'd0, PREADY}, 32'd0);
      end
   end

   // Leaves the bus driven as-is on return so a following call is back-to-back.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input int abort_after, input string name);
      exp_t e;
      int   n;
      bit   v;
      int   idx;
      v   = (addr < 32'(4 * NREGS));
      idx = int'(addr[5:2]);
      if (abort_after < 0) begin
         e.waits = (v && idx >= NREGS / 2) ? WAITS : 0;
         e.err   = !v;
         e.rdata = (!wr && v) ? model[idx] : 32'd0;
         e.name  = name;
         exp_q.push_back(e);
         if (wr && v) model[idx] = wd;
      end
      PSELx = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wd;
      @(posedge i_clk); #1 PENABLE = 1'b1;
      n = 0;
      forever begin
         @(negedge i_clk);
         if (PREADY) break;
         n++;
         if (abort_after >= 0 && n >= abort_after) begin
            @(posedge i_clk); #1 PSELx = 1'b0; PENABLE = 1'b0;
            return;
         end
         if (n > 20) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no PREADY after %0d access cycles, required within %0d", name, n, WAITS + 1);
            @(posedge i_clk); #1 PSELx = 1'b0; PENABLE = 1'b0;
            return;
         end
      end
      @(posedge i_clk); #1;
   endtask

   task automatic bus_idle();
      PSELx = 1'b0; PENABLE = 1'b0;
      @(posedge i_clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < NREGS; i++) model[i] = '0;
      repeat (2) @(posedge i_clk);
      #1;
      check32("reset_pready", {31'd0, PREADY}, 32'd0);
      check32("reset_pslverr", {31'd0, PSLVERR}, 32'd0);
      check32("reset_prdata", PRDATA, 32'd0);
      i_reset = 1'b0;
      @(posedge i_clk); #1;

      xfer(32'h04, 1'b1, 32'hDEADBEEF, -1, "wr_04");
      bus_idle();
      xfer(32'h04, 1'b0, 32'h0, -1, "rd_04");
      xfer(32'h05, 1'b0, 32'h0, -1, "rd_05");
      bus_idle();
      xfer(32'h20, 1'b0, 32'h0, -1, "rd_20_before");
      xfer(32'h20, 1'b1, 32'hCAFEBABE, -1, "wr_20_slow");
      xfer(32'h20, 1'b0, 32'h0, -1, "rd_20_after");
      xfer(32'hFFFF_FFFF, 1'b1, 32'h12345678, -1, "wr_invalid");
      xfer(32'h40, 1'b0, 32'h0, -1, "rd_40_invalid");
      xfer(32'h3C, 1'b0, 32'h0, -1, "rd_3c_last");
      bus_idle();

      // Reset during the wait states of a slow write.
      PSELx = 1'b1; PENABLE = 1'b0; PADDR = 32'h24; PWRITE = 1'b1; PWDATA = 32'hA5A5A5A5;
      @(posedge i_clk); #1 PENABLE = 1'b1;
      @(posedge i_clk); #1 i_reset = 1'b1;
      #1;
      check32("rst_mid_pready", {31'd0, PREADY}, 32'd0);
      check32("rst_mid_pslverr", {31'd0, PSLVERR}, 32'd0);
      check32("rst_mid_prdata", PRDATA, 32'd0);
      for (int i = 0; i < NREGS; i++) model[i] = '0;
      PSELx = 1'b0; PENABLE = 1'b0;
      @(posedge i_clk); #1 i_reset = 1'b0;
      @(posedge i_clk); #1;
      xfer(32'h24, 1'b0, 32'h0, -1, "rd_24_after_rst");
      xfer(32'h04, 1'b0, 32'h0, -1, "rd_04_after_rst");
      bus_idle();

      // Protocol abort after one wait cycle, then a zero-wait read.
      xfer(32'h28, 1'b1, 32'h5555AAAA, 1, "wr_28_abort");
      xfer(32'h00, 1'b0, 32'h0, -1, "rd_00_b2b");
      xfer(32'h28, 1'b0, 32'h0, -1, "rd_28_not_written");
      bus_idle();

      for (int t = 0; t < 60; t++) begin
         logic [31:0] a;
         logic        w;
         a = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 63));
         w = 1'($urandom_range(0, 1));
         xfer(a, w, $urandom(), -1, $sformatf("rnd%0d", t));
         if ($urandom_range(0, 2) == 0) bus_idle();
      end
      bus_idle();
      for (int i = 0; i < NREGS; i++) begin
         xfer(32'(4 * i), 1'b0, 32'h0, -1, $sformatf("sweep%0d", i));
      end
      bus_idle();
      repeat (3) @(posedge i_clk);
      check32("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
